// File: rtl/wb_uart_fifo_pkg.sv
// Shared definitions for the Wishbone UART: register offsets, STAT/IER bit
// positions and the encodings of the RX and TX control FSMs.
package wb_uart_fifo_pkg;

  localparam logic [1:0] REG_STAT = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_IER  = 2'd2;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_RX_ERR   = 1;
  localparam int STAT_RX_OVF   = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_TX_IDLE  = 4;
  localparam int STAT_TX_OVF   = 5;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_ERR = 2;

  typedef enum logic {R_IDLE, R_ACK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT} tx_state_t;

  // Both FSM states bundled so a checker can bind to a single signal.
  typedef struct packed {
    rx_state_t rx;
    tx_state_t tx;
  } fsm_state_t;

endpackage

// File: rtl/uart.sv
// 8N1 serial engine: one-shot transmitter loaded by tx_wr, and a receiver
// that samples mid-bit and holds each byte in rx_data until rx_ack.
module uart #(
  parameter int freq_hz = 50000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int DIV = freq_hz / baud;
  localparam int CW  = $clog2(DIV + 1);

  logic [9:0]    tx_sh;
  logic [3:0]    tx_cnt, rx_cnt;
  logic [CW-1:0] tx_div, rx_div;
  logic [1:0]    rx_sync;
  logic          rx_on;
  logic [7:0]    rx_sh;

  assign uart_txd = tx_busy ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_div  <= '0;
    end else if (!tx_busy) begin
      if (tx_wr) begin
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_div  <= '0;
      end
    end else if (tx_div == CW'(DIV - 1)) begin
      tx_div <= '0;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      if (tx_cnt == 4'd9) tx_busy <= 1'b0;
      else                tx_cnt  <= tx_cnt + 4'd1;
    end else begin
      tx_div <= tx_div + CW'(1);
    end
  end

  // rx_cnt: 0 = start-bit check, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_on    <= 1'b0;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd};
      if (rx_ack) rx_avail <= 1'b0;
      if (!rx_on) begin
        if (!rx_sync[1]) begin
          rx_on  <= 1'b1;
          rx_div <= CW'(DIV / 2);
          rx_cnt <= '0;
        end
      end else if (rx_div == CW'(DIV - 1)) begin
        rx_div <= '0;
        if (rx_cnt == 4'd0) begin
          if (rx_sync[1]) rx_on  <= 1'b0;
          else            rx_cnt <= 4'd1;
        end else if (rx_cnt != 4'd9) begin
          rx_sh  <= {rx_sync[1], rx_sh[7:1]};
          rx_cnt <= rx_cnt + 4'd1;
        end else begin
          rx_data  <= rx_sh;
          rx_avail <= 1'b1;
          rx_error <= ~rx_sync[1];
          rx_on    <= 1'b0;
        end
      end else begin
        rx_div <= rx_div + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read data and an occupancy
// level; pushes while full and pops while empty are silently ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone UART slave: RX/TX FIFOs around the serial engine, sticky error
// flags, interrupt enables and a registered level interrupt.
module wb_uart_fifo
  import wb_uart_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);

  logic        ack, take, wr_en, rd_en;
  logic [1:0]  reg_sel;
  logic [2:0]  ier;
  logic        rx_err, rx_ovf, tx_ovf, tx_idle;
  logic        tx_push, rx_pop, stat_w1c;
  logic [31:0] stat_word, rd_word;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;
  fsm_state_t  fsm_state;

  logic [7:0]  rx_rdata, tx_rdata, eng_rx_data, tx_data;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [ADDR_W:0] rx_level, tx_level;
  logic        eng_rx_avail, eng_rx_error, eng_tx_busy;
  logic        rx_push, rx_ack, tx_pop, tx_wr;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  // Handshake: a strobe is taken only while ack is low, so every ack is
  // followed by one idle cycle before the next access is accepted.
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
  assign take     = wb_stb_i & wb_cyc_i & ~ack;
  assign reg_sel  = wb_adr_i[3:2];
  assign wr_en    = take & wb_we_i & wb_sel_i[0];
  assign rd_en    = take & ~wb_we_i;
  assign tx_push  = wr_en & (reg_sel == REG_DATA);
  assign stat_w1c = wr_en & (reg_sel == REG_STAT);
  assign rx_pop   = rd_en & (reg_sel == REG_DATA);
  assign tx_idle  = tx_empty & ~eng_tx_busy;

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_RX_AVAIL] = ~rx_empty;
    stat_word[STAT_RX_ERR]   = rx_err;
    stat_word[STAT_RX_OVF]   = rx_ovf;
    stat_word[STAT_TX_FULL]  = tx_full;
    stat_word[STAT_TX_IDLE]  = tx_idle;
    stat_word[STAT_TX_OVF]   = tx_ovf;
    stat_word[15:8]          = 8'(rx_level);
    stat_word[23:16]         = 8'(tx_level);
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STAT: rd_word = stat_word;
      REG_DATA: rd_word = {24'b0, rx_empty ? 8'h00 : rx_rdata};
      REG_IER:  rd_word = {29'b0, ier};
      default:  rd_word = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack      <= 1'b0;
      wb_dat_o <= '0;
      ier      <= '0;
      rx_err   <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      irq      <= 1'b0;
      tx_data  <= '0;
    end else begin
      ack <= take;
      if (rd_en) wb_dat_o <= rd_word;
      if (wr_en && reg_sel == REG_IER) ier <= wb_dat_i[2:0];
      rx_err <= (rx_err & ~(stat_w1c & wb_dat_i[STAT_RX_ERR])) | (rx_push & eng_rx_error);
      rx_ovf <= (rx_ovf & ~(stat_w1c & wb_dat_i[STAT_RX_OVF])) | (rx_push & rx_full);
      tx_ovf <= (tx_ovf & ~(stat_w1c & wb_dat_i[STAT_TX_OVF])) | (tx_push & tx_full);
      irq <= (ier[IER_RX] & ~rx_empty) | (ier[IER_TX] & tx_idle) |
             (ier[IER_ERR] & (rx_err | rx_ovf | tx_ovf));
      if (tx_pop) tx_data <= tx_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
      tx_state <= T_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    tx_next = tx_state;
    case (rx_state)
      R_IDLE:  if (eng_rx_avail) rx_next = R_ACK;
      default: rx_next = R_IDLE;
    endcase
    case (tx_state)
      T_IDLE:  if (!tx_empty && !eng_tx_busy) tx_next = T_LOAD;
      T_LOAD:  tx_next = T_WAIT;
      default: tx_next = T_IDLE;
    endcase
  end

  // R_ACK gives the engine a cycle to drop rx_avail; T_WAIT covers the
  // cycle before tx_busy rises after tx_wr.
  always_comb begin
    fsm_state = '{rx: rx_state, tx: tx_state};
    rx_push   = (fsm_state.rx == R_IDLE) & eng_rx_avail;
    rx_ack    = (fsm_state.rx == R_ACK);
    tx_pop    = (fsm_state.tx == T_IDLE) & ~tx_empty & ~eng_tx_busy;
    tx_wr     = (fsm_state.tx == T_LOAD);
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(reset_n), .push(rx_push), .pop(rx_pop),
    .wdata(eng_rx_data), .rdata(rx_rdata), .full(rx_full),
    .empty(rx_empty), .level(rx_level)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(reset_n), .push(tx_push), .pop(tx_pop),
    .wdata(wb_dat_i[7:0]), .rdata(tx_rdata), .full(tx_full),
    .empty(tx_empty), .level(tx_level)
  );

  uart #(.freq_hz(CLK_FREQ), .baud(BAUD)) u_uart (
    .clk(clk), .reset(~reset_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_data(eng_rx_data), .rx_avail(eng_rx_avail), .rx_error(eng_rx_error),
    .rx_ack(rx_ack), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(eng_tx_busy)
  );

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed bench for wb_uart_fifo: loopback, TX/RX overflow, interrupts,
// and asynchronous reset in the middle of traffic.
module tb_wb_uart_fifo;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 125000;
  localparam int DEPTH    = 4;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_ack_o, irq, uart_txd, uart_rxd;
  logic [31:0] wb_dat_o;
  logic        loop_en = 1'b0, rxd_drv = 1'b1;

  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  logic [7:0] mon_byte;
  logic [31:0] rd;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  wb_uart_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    bit got_ack = 0;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got_ack = 1; break; end
    end
    if (!got_ack) check("wb_ack_timeout", 32'd0, 32'd1);
    rdat = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, 4'h1, d);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] dat);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, dat);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) rxd_drv = fr[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  // Serial monitor on uart_txd: samples each bit in its middle
  always begin
    @(negedge uart_txd);
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      mon_byte[i] = uart_txd;
    end
    repeat (BIT) @(negedge clk);
    mon_q.push_back(mon_byte);
  end

  // Scoreboard: transmitted frames against the expected queue
  task automatic compare_tx(input string tag);
    check({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && mon_q.size() > 0)
      check({tag, "_byte"}, 32'(mon_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    mon_q.delete();
  endtask

  initial begin
    // Reset state
    cycles(3);
    check("rst_dat_o", wb_dat_o, 32'h0);
    check("rst_ack", 32'(wb_ack_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_txd", 32'(uart_txd), 32'h1);
    @(negedge clk) reset_n = 1'b1;
    cycles(2);
    wb_rd(32'h0, rd);  check("rst_stat", rd, 32'h0000_0010);
    wb_rd(32'h8, rd);  check("rst_ier", rd, 32'h0);
    wb_rd(32'hC, rd);  check("reg_c_read", rd, 32'h0);
    check("rst_irq_after", 32'(irq), 32'h0);

    // Loopback of three bytes
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_wr(32'h4, 32'h41 + 32'(i));
      exp_q.push_back(8'h41 + 8'(i));
    end
    cycles(400);
    compare_tx("loop_tx");
    wb_rd(32'h0, rd);  check("loop_stat", rd, 32'h0000_0311);
    wb_rd(32'h4, rd);  check("loop_rd0", rd, 32'h41);
    wb_rd(32'h4, rd);  check("loop_rd1", rd, 32'h42);
    wb_rd(32'h4, rd);  check("loop_rd2", rd, 32'h43);
    wb_rd(32'h4, rd);  check("loop_rd_empty", rd, 32'h0);
    wb_rd(32'h0, rd);  check("loop_stat_end", rd, 32'h0000_0010);
    loop_en = 1'b0;

    // TX overflow: first byte enters the engine, DEPTH fill the FIFO, last is dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      wb_wr(32'h4, 32'h50 + 32'(i));
      if (i < DEPTH + 1) exp_q.push_back(8'h50 + 8'(i));
    end
    wb_rd(32'h0, rd);  check("txovf_stat", rd, 32'h0004_0028);
    wb_wr(32'h0, 32'h20);
    wb_rd(32'h0, rd);  check("txovf_clear", rd, 32'h0004_0008);
    cycles(600);
    compare_tx("txovf_tx");
    wb_rd(32'h0, rd);  check("txovf_stat_end", rd, 32'h0000_0010);

    // RX overflow and error interrupt
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h60 + 8'(i));
    cycles(10);
    wb_rd(32'h0, rd);  check("rxovf_stat", rd, 32'h0000_0415);
    check("rxovf_irq_off", 32'(irq), 32'h0);
    wb_wr(32'h8, 32'h4);
    cycles(2);
    check("rxovf_irq_on", 32'(irq), 32'h1);
    wb_wr(32'h0, 32'h04);
    cycles(2);
    check("rxovf_irq_clr", 32'(irq), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      wb_rd(32'h4, rd);
      check("rxovf_drain", rd, 32'h60 + 32'(i));
    end
    wb_rd(32'h0, rd);  check("rxovf_stat_end", rd, 32'h0000_0010);

    // RX-available and TX-idle interrupts
    wb_wr(32'h8, 32'h1);
    cycles(2);
    check("irq_rx_idle", 32'(irq), 32'h0);
    send_byte(8'h7A);
    cycles(10);
    check("irq_rx_set", 32'(irq), 32'h1);
    wb_rd(32'h4, rd);
    check("irq_rx_data", rd, 32'h7A);
    check("irq_rx_at_ack", 32'(irq), 32'h1);
    cycles(1);
    check("irq_rx_drop", 32'(irq), 32'h0);
    wb_wr(32'h8, 32'h2);
    cycles(2);
    check("irq_tx_idle", 32'(irq), 32'h1);

    // Write with lane 0 disabled has no effect
    begin
      logic [31:0] d;
      wb_xfer(1'b1, 32'h4, 32'h99, 4'hE, d);
    end
    cycles(200);
    check("sel0_frames", 32'(mon_q.size()), 32'h0);
    wb_rd(32'h8, rd);  check("sel0_ier", rd, 32'h2);
    wb_rd(32'h0, rd);  check("sel0_stat", rd, 32'h0000_0010);

    // Asynchronous reset during a loopback burst
    loop_en = 1'b1;
    wb_wr(32'h4, 32'h11);
    wb_wr(32'h4, 32'h22);
    wb_wr(32'h4, 32'h33);
    cycles(40);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("mid_rst_dat_o", wb_dat_o, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_ack", 32'(wb_ack_o), 32'h0);
    check("mid_rst_txd", 32'(uart_txd), 32'h1);
    cycles(5);
    @(negedge clk) reset_n = 1'b1;
    loop_en = 1'b0;
    cycles(200);
    mon_q.delete();
    wb_rd(32'h0, rd);  check("post_rst_stat", rd, 32'h0000_0010);
    wb_rd(32'h8, rd);  check("post_rst_ier", rd, 32'h0);
    wb_rd(32'h4, rd);  check("post_rst_data", rd, 32'h0);
    cycles(200);
    check("post_rst_frames", 32'(mon_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
